// File: rtl/fixed_mul_pkg.sv
// Shared types and helpers for the multiplier-sharing arbiter.
// Tag ids are carried at a fixed width; the top narrows them to its requester count.
package fixed_mul_pkg;

    localparam int MUL_WIDTH = 26;
    localparam int TAG_ID_W  = 8;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    function automatic int mul_lat(input int w);
        return w / 2 + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, search starts at the pointer and wraps.
// Latency 0 for grant; pointer moves past the winner on the following edge. en=0 masks all grants.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr_q, ptr_d;

    always_comb begin : search
        logic          found;
        logic [IW-1:0] idx;
        found     = 1'b0;
        idx       = '0;
        grant     = '0;
        grant_idx = '0;
        for (int k = 0; k < N; k++) begin
            idx = IW'((int'(ptr_q) + k) % N);
            if (en && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
        ptr_d = found ? IW'((int'(grant_idx) + 1) % N) : ptr_q;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/fixed_mul_arbiter.sv
// Shares one pipelined multiplier among N_REQ requesters, returning each product to its owner.
// Latency: accept in cycle t -> rsp_valid in t+MUL_LAT+2; one issue per cycle.
// Backpressure: only via req_ready (round-robin, gated by hold); responses are never stalled.
module fixed_mul_arbiter
    import fixed_mul_pkg::*;
#(
    parameter  int N_REQ   = 4,
    parameter  int WIDTH   = MUL_WIDTH,
    parameter  int MUL_LAT = mul_lat(WIDTH),
    localparam int IDW     = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CNTW    = $clog2(MUL_LAT + 3)
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_din1,
    input  logic [N_REQ*WIDTH-1:0] req_din2,
    input  logic                   hold,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [2*WIDTH-1:0]     rsp_dout,
    output logic [IDW-1:0]         rsp_id,
    output logic [WIDTH-1:0]       mul_din1,
    output logic [WIDTH-1:0]       mul_din2,
    output logic                   mul_din_valid,
    input  logic [2*WIDTH-1:0]     mul_dout,
    input  logic                   mul_dout_valid,
    output logic                   idle,
    output logic                   err
);

    logic [IDW-1:0]     gnt_idx;
    logic               hs;
    tag_t               issue_tag_q, issue_tag_d;
    logic [WIDTH-1:0]   din1_q, din1_d, din2_q, din2_d;
    tag_t               line_q [MUL_LAT];
    tag_t               tag_out;
    logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [2*WIDTH-1:0] rsp_dout_q;
    logic [IDW-1:0]     rsp_id_q;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic               err_q;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk       (clk),
        .nrst      (nrst),
        .req       (req_valid),
        .en        (!hold),
        .grant     (req_ready),
        .grant_idx (gnt_idx)
    );

    assign hs = |req_ready;

    always_comb begin
        issue_tag_d.valid = hs;
        issue_tag_d.id    = TAG_ID_W'(gnt_idx);
        din1_d = din1_q;
        din2_d = din2_q;
        if (hs) begin
            din1_d = req_din1[int'(gnt_idx)*WIDTH +: WIDTH];
            din2_d = req_din2[int'(gnt_idx)*WIDTH +: WIDTH];
        end
        // Tag line output lines up with mul_dout_valid of the same op.
        tag_out     = line_q[MUL_LAT-1];
        rsp_valid_d = (tag_out.valid && mul_dout_valid) ? (N_REQ'(1) << tag_out.id) : '0;
        cnt_d = cnt_q;
        if (hs && !tag_out.valid)      cnt_d = cnt_q + 1'b1;
        else if (!hs && tag_out.valid) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            issue_tag_q <= '0;
            din1_q      <= '0;
            din2_q      <= '0;
            for (int k = 0; k < MUL_LAT; k++) line_q[k] <= '0;
            rsp_valid_q <= '0;
            rsp_dout_q  <= '0;
            rsp_id_q    <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            issue_tag_q <= issue_tag_d;
            din1_q      <= din1_d;
            din2_q      <= din2_d;
            line_q[0]   <= issue_tag_q;
            for (int k = 1; k < MUL_LAT; k++) line_q[k] <= line_q[k-1];
            rsp_valid_q <= rsp_valid_d;
            rsp_dout_q  <= mul_dout;
            rsp_id_q    <= tag_out.id[IDW-1:0];
            cnt_q       <= cnt_d;
            err_q       <= err_q | (tag_out.valid ^ mul_dout_valid);
        end
    end

    assign mul_din1      = din1_q;
    assign mul_din2      = din2_q;
    assign mul_din_valid = issue_tag_q.valid;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_dout      = rsp_dout_q;
    assign rsp_id        = rsp_id_q;
    assign idle          = (cnt_q == '0) && !(|req_valid);
    assign err           = err_q;

endmodule

// File: tb/tb_fixed_mul_arbiter.sv
// Scoreboard bench: stimulus pushes expected products, a monitor pops them on rsp_valid.
module tb_fixed_mul_arbiter;

    localparam int N = 4;
    localparam int W = 26;
    localparam int L = 14;

    logic             clk, nrst, hold;
    logic [N-1:0]     req_valid, req_ready, rsp_valid;
    logic [N*W-1:0]   req_din1, req_din2;
    logic [2*W-1:0]   rsp_dout, mul_dout;
    logic [1:0]       rsp_id;
    logic [W-1:0]     mul_din1, mul_din2;
    logic             mul_din_valid, mul_dout_valid, idle, err;

    fixed_mul_arbiter #(.N_REQ(N), .WIDTH(W), .MUL_LAT(L)) dut (
        .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_ready(req_ready),
        .req_din1(req_din1), .req_din2(req_din2), .hold(hold),
        .rsp_valid(rsp_valid), .rsp_dout(rsp_dout), .rsp_id(rsp_id),
        .mul_din1(mul_din1), .mul_din2(mul_din2), .mul_din_valid(mul_din_valid),
        .mul_dout(mul_dout), .mul_dout_valid(mul_dout_valid), .idle(idle), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [2*W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return (2*W)'(sa * sb);
    endfunction

    // Behavioural multiplier: fixed latency L, can lose the valid of one chosen issue.
    logic [L-1:0]   m_v;
    logic [2*W-1:0] m_p [L];
    int             iss_n;
    int             drop_k = -1;
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_v   <= '0;
            iss_n <= 0;
            for (int k = 0; k < L; k++) m_p[k] <= '0;
        end else begin
            m_v    <= {m_v[L-2:0], mul_din_valid && (iss_n != drop_k)};
            m_p[0] <= prod(mul_din1, mul_din2);
            for (int k = 1; k < L; k++) m_p[k] <= m_p[k-1];
            if (mul_din_valid) iss_n <= iss_n + 1;
        end
    end
    assign mul_dout_valid = m_v[L-1];
    assign mul_dout       = m_p[L-1];

    typedef struct {
        int             id;
        logic [2*W-1:0] p;
        int             due;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin
        if (nrst && |rsp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 64'(rsp_valid), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_valid", 64'(rsp_valid), 64'(1) << e.id);
                check("rsp_id", 64'(rsp_id), 64'(e.id));
                check("rsp_dout", 64'(rsp_dout), 64'(e.p));
                check("rsp_latency", 64'(cyc), 64'(e.due));
            end
        end
    end

    logic [W-1:0] a_pend [N];
    logic [W-1:0] b_pend [N];
    logic [N-1:0] acc_last;
    int           ptr_m = 0;
    int           hs_n  = 0;

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            req_din1[i*W +: W] = a_pend[i];
            req_din2[i*W +: W] = b_pend[i];
        end
    endtask

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(5))
            0:       return {1'b0, {(W-1){1'b1}}};
            1:       return {1'b1, {(W-1){1'b0}}};
            2:       return '1;
            default: return W'($urandom());
        endcase
    endfunction

    // One cycle: predict the grant from the round-robin rule, record accepted ops, advance.
    task automatic step();
        logic [N-1:0] eg;
        int           w;
        exp_t         e;
        @(negedge clk);
        eg = '0;
        w  = -1;
        if (!hold) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (ptr_m + k) % N;
                if (w < 0 && req_valid[i]) w = i;
            end
        end
        if (w >= 0) eg[w] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(eg));
        acc_last = eg;
        if (w >= 0) begin
            if (hs_n != drop_k) begin
                e.id  = w;
                e.p   = prod(a_pend[w], b_pend[w]);
                e.due = cyc + L + 2;
                sb.push_back(e);
            end
            hs_n++;
            ptr_m = (w + 1) % N;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_update(input logic [N-1:0] mask, input int pct);
        for (int i = 0; i < N; i++) begin
            if (!(req_valid[i] && !acc_last[i])) begin
                if (mask[i] && $urandom_range(99) < pct) begin
                    a_pend[i]    = rnd_op();
                    b_pend[i]    = rnd_op();
                    req_valid[i] = 1'b1;
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        apply();
    endtask

    task automatic run(input logic [N-1:0] mask, input int pct, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            rand_update(mask, pct);
            step();
        end
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        req_valid = '0;
        apply();
        while (sb.size() != 0 && k < budget) begin
            step();
            k++;
        end
        step();
        check("drain_empty", 64'(sb.size()), 64'd0);
        check("idle_after_drain", 64'(idle), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] da [3];
        logic [W-1:0] db [3];
        nrst      = 1'b0;
        hold      = 1'b0;
        req_valid = '0;
        acc_last  = '0;
        for (int i = 0; i < N; i++) begin
            a_pend[i] = '0;
            b_pend[i] = '0;
        end
        apply();
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_mul_din_valid", 64'(mul_din_valid), 64'd0);
        check("rst_mul_din1", 64'(mul_din1), 64'd0);
        check("rst_rsp_dout", 64'(rsp_dout), 64'd0);
        check("rst_rsp_id", 64'(rsp_id), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_idle", 64'(idle), 64'd1);
        nrst = 1'b1;

        // Single requester, back-to-back directed pairs.
        da[0] = -26'sd3;            db[0] = 26'sd5;
        da[1] = 26'sd7;             db[1] = 26'sd7;
        da[2] = 26'h1FF_FFFF;       db[2] = '1;
        for (int j = 0; j < 3; j++) begin
            a_pend[0] = da[j];
            b_pend[0] = db[j];
            req_valid = 4'b0001;
            apply();
            step();
        end
        drain(40);
        check("err_directed", 64'(err), 64'd0);

        // All requesters saturating, then a sparse pair of requesters.
        run(4'b1111, 100, 40);
        run(4'b1010, 100, 20);
        run(4'b1010, 60, 40);
        drain(40);

        // Hold asserted mid-stream.
        run(4'b1111, 80, 20);
        hold = 1'b1;
        run(4'b1111, 80, 5);
        hold = 1'b0;
        run(4'b1111, 80, 10);
        hold = 1'b1;
        drain(40);
        hold = 1'b0;

        // Reset with ops in flight.
        run(4'b1111, 100, 10);
        nrst      = 1'b0;
        req_valid = '0;
        apply();
        sb.delete();
        hs_n  = 0;
        ptr_m = 0;
        #2;
        check("inrst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("inrst_idle", 64'(idle), 64'd1);
        check("inrst_mul_din_valid", 64'(mul_din_valid), 64'd0);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        for (int c = 0; c < L + 6; c++) step();
        check("post_rst_idle", 64'(idle), 64'd1);
        check("post_rst_err", 64'(err), 64'd0);
        for (int i = 0; i < N; i++) begin
            a_pend[i] = rnd_op();
            b_pend[i] = rnd_op();
        end
        req_valid = 4'b1111;
        apply();
        step();
        drain(40);

        // One multiplier result goes missing.
        drop_k = hs_n + 5;
        run(4'b1111, 70, 30);
        drain(40);
        check("err_set", 64'(err), 64'd1);
        drop_k = -1;
        run(4'b0111, 70, 30);
        drain(40);
        check("err_sticky", 64'(err), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
